// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, redirect/exception steering, and an IF/ID slot
// with a one-entry skid buffer so that ID outputs stay frozen across stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] ISR_PC     = 32'h0000_4180,
  parameter int unsigned DELAY_SLOT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  output logic [31:0] im_addr,
  output logic        im_enable,
  input  logic [31:0] im_result,
  input  logic        im_valid,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_adel
);

  logic [31:0] pc_f_q, pc_f_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_adel_q, id_adel_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic        redir_take;
  logic [31:0] redir_tgt;

  // A redirect arriving on the applying edge is newer than any latched one.
  assign redir_take = redirect_valid | pend_valid_q;
  assign redir_tgt  = redirect_valid ? redirect_pc : pend_pc_q;

  always_comb begin
    pc_f_d       = pc_f_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_adel_d    = id_adel_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;

    if (exc_req) begin
      pc_f_d       = ISR_PC;
      id_valid_d   = 1'b0;
      id_adel_d    = 1'b0;
      hold_valid_d = 1'b0;
      pend_valid_d = 1'b0;
    end else if (stall) begin
      // The memory keeps reading the held PC, so capture the ID word before it is lost.
      if (!hold_valid_q) begin
        hold_instr_d = im_result;
        hold_valid_d = 1'b1;
      end
      if (redirect_valid) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = redirect_pc;
      end
    end else begin
      hold_valid_d = 1'b0;
      pend_valid_d = 1'b0;
      id_pc_d      = pc_f_q;
      id_adel_d    = !im_valid;
      id_valid_d   = 1'b1;
      if (redir_take) begin
        pc_f_d = redir_tgt;
        if (DELAY_SLOT == 0) id_valid_d = 1'b0;
      end else begin
        pc_f_d = pc_f_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_f_q       <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_pc_q      <= 32'h0;
      id_adel_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= 32'h0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
    end else begin
      pc_f_q       <= pc_f_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_adel_q    <= id_adel_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign im_addr   = pc_f_q;
  assign im_enable = reset_n;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_adel   = id_adel_q;
  assign id_instr  = id_adel_q    ? 32'h0 :
                     hold_valid_q ? hold_instr_q : im_result;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one delay-slot instance and one kill-slot instance
// share the same stimulus, each with its own synchronous memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_req;

  logic [31:0] im_addr, d0_im_addr;
  logic        im_enable, d0_im_enable;
  logic [31:0] im_result, d0_im_result;
  logic        im_valid, d0_im_valid;
  logic        id_valid, d0_id_valid;
  logic [31:0] id_pc, d0_id_pc;
  logic [31:0] id_instr, d0_id_instr;
  logic        id_adel, d0_id_adel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory word at address a is a ^ 32'hDEAD_0000; valid below 64 KiB and word-aligned.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'h0001_0000);
  endfunction

  always_ff @(posedge clk) begin
    im_result    <= mem_word(im_addr);
    d0_im_result <= mem_word(d0_im_addr);
  end
  assign im_valid    = addr_ok(im_addr);
  assign d0_im_valid = addr_ok(d0_im_addr);

  fetch_unit #(.DELAY_SLOT(1)) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .exc_req       (exc_req),
    .im_addr       (im_addr),
    .im_enable     (im_enable),
    .im_result     (im_result),
    .im_valid      (im_valid),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .id_adel       (id_adel)
  );

  fetch_unit #(.DELAY_SLOT(0)) u_ds0 (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .exc_req       (exc_req),
    .im_addr       (d0_im_addr),
    .im_enable     (d0_im_enable),
    .im_result     (d0_im_result),
    .im_valid      (d0_im_valid),
    .id_valid      (d0_id_valid),
    .id_pc         (d0_id_pc),
    .id_instr      (d0_id_instr),
    .id_adel       (d0_id_adel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] instr, input logic adel, input logic [31:0] addr);
    chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, v});
    chk({tag, ".id_pc"}, id_pc, pc);
    chk({tag, ".id_instr"}, id_instr, instr);
    chk({tag, ".id_adel"}, {31'b0, id_adel}, {31'b0, adel});
    chk({tag, ".im_addr"}, im_addr, addr);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".im_addr"}, im_addr, 32'h0000_3000);
    chk({tag, ".im_enable"}, {31'b0, im_enable}, 32'h0);
    chk({tag, ".id_valid"}, {31'b0, id_valid}, 32'h0);
    chk({tag, ".id_pc"}, id_pc, 32'h0);
    chk({tag, ".id_adel"}, {31'b0, id_adel}, 32'h0);
    chk({tag, ".d0_id_valid"}, {31'b0, d0_id_valid}, 32'h0);
    chk({tag, ".d0_im_addr"}, d0_im_addr, 32'h0000_3000);
  endtask

  initial begin
    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    exc_req        = 1'b0;
    tick();
    chk_reset("rst0");
    reset_n = 1'b1;

    // Sequential fetch from reset
    tick();
    chk_id("seq0", 1'b1, 32'h3000, 32'hDEAD_3000, 1'b0, 32'h3004);
    chk("seq0.im_enable", {31'b0, im_enable}, 32'h1);
    tick();
    chk_id("seq1", 1'b1, 32'h3004, 32'hDEAD_3004, 1'b0, 32'h3008);
    tick();
    chk_id("seq2", 1'b1, 32'h3008, 32'hDEAD_3008, 1'b0, 32'h300C);

    // Three-cycle stall at 0x3008
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_id($sformatf("stall%0d", i), 1'b1, 32'h3008, 32'hDEAD_3008, 1'b0, 32'h300C);
    end
    stall = 1'b0;
    tick();
    chk_id("seq3", 1'b1, 32'h300C, 32'hDEAD_300C, 1'b0, 32'h3010);

    // Redirect latched during stall, applied when stall drops
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3200;
    tick();
    redirect_valid = 1'b0;
    chk_id("pend0", 1'b1, 32'h300C, 32'hDEAD_300C, 1'b0, 32'h3010);
    tick();
    tick();
    chk_id("pend2", 1'b1, 32'h300C, 32'hDEAD_300C, 1'b0, 32'h3010);
    stall = 1'b0;
    tick();
    chk_id("pend_apply", 1'b1, 32'h3010, 32'hDEAD_3010, 1'b0, 32'h3200);
    chk("pend_apply.d0_id_valid", {31'b0, d0_id_valid}, 32'h0);
    chk("pend_apply.d0_im_addr", d0_im_addr, 32'h3200);
    tick();
    chk_id("pend_tgt", 1'b1, 32'h3200, 32'hDEAD_3200, 1'b0, 32'h3204);
    chk("pend_tgt.d0_id_valid", {31'b0, d0_id_valid}, 32'h1);

    // Reset with a pending redirect discards it
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3300;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    reset_n        = 1'b0;
    #1;
    chk_reset("rst1");
    reset_n = 1'b1;
    tick();
    chk_id("rst1_e1", 1'b1, 32'h3000, 32'hDEAD_3000, 1'b0, 32'h3004);
    tick();
    chk_id("rst1_e2", 1'b1, 32'h3004, 32'hDEAD_3004, 1'b0, 32'h3008);

    // Branch at 0x3004 to 0x3100
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3100;
    tick();
    redirect_valid = 1'b0;
    chk_id("br_slot", 1'b1, 32'h3008, 32'hDEAD_3008, 1'b0, 32'h3100);
    chk("br_slot.d0_id_valid", {31'b0, d0_id_valid}, 32'h0);
    chk("br_slot.d0_id_pc", d0_id_pc, 32'h3008);
    tick();
    chk_id("br_tgt", 1'b1, 32'h3100, 32'hDEAD_3100, 1'b0, 32'h3104);
    chk("br_tgt.d0_id_valid", {31'b0, d0_id_valid}, 32'h1);
    chk("br_tgt.d0_id_pc", d0_id_pc, 32'h3100);

    // Exception while stalled
    stall   = 1'b1;
    exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    stall   = 1'b0;
    chk("exc.id_valid", {31'b0, id_valid}, 32'h0);
    chk("exc.im_addr", im_addr, 32'h4180);
    chk("exc.id_adel", {31'b0, id_adel}, 32'h0);
    tick();
    chk_id("exc_isr", 1'b1, 32'h4180, 32'hDEAD_4180, 1'b0, 32'h4184);

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3002;
    tick();
    redirect_valid = 1'b0;
    chk_id("mis_slot", 1'b1, 32'h4184, 32'hDEAD_4184, 1'b0, 32'h3002);
    tick();
    chk_id("mis0", 1'b1, 32'h3002, 32'h0, 1'b1, 32'h3006);
    tick();
    chk_id("mis1", 1'b1, 32'h3006, 32'h0, 1'b1, 32'h300A);

    // Asynchronous reset mid-sequence
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter ISR_PC, 32'h0000_4180, fetch target on exception/interrupt entry.
REQ-003 Parameter DELAY_SLOT, 1, 1 = redirect keeps the in-flight fetch (MIPS delay slot), 0 = redirect kills it.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  decode stage cannot accept; hold PC and ID outputs.
REQ-007 redirect_valid  in  1  branch/jump taken, one-cycle pulse.
REQ-008 redirect_pc  in  32  redirect target.
REQ-009 exc_req  in  1  exception/interrupt entry, one-cycle pulse.
REQ-010 im_addr  out  32  fetch address to instruction memory.
REQ-011 im_enable  out  1  fetch request to instruction memory.
REQ-012 im_result  in  32  synchronous-read instruction word; valid one cycle after im_addr.
REQ-013 im_valid  in  1  address in range and word-aligned, qualifying im_result.
REQ-014 id_valid  out  1  ID slot holds a live instruction.
REQ-015 id_pc  out  32  PC of the instruction in ID.
REQ-016 id_instr  out  32  instruction word for ID.
REQ-017 id_adel  out  1  fetch address error for the ID instruction.

Function
REQ-018 Register pc_f SHALL drive im_addr directly; im_enable SHALL be 1 whenever reset_n is 1, 0 otherwise.
REQ-019 Next pc_f priority: exc_req -> ISR_PC; else stall -> hold; else pending redirect or redirect_valid -> target; else pc_f+4 (32-bit, wraps modulo 2^32).
REQ-020 redirect_valid during stall SHALL be latched into pend_valid/pend_pc and applied at the first non-stall edge; a newer redirect overwrites it; exc_req clears it.
REQ-021 On a non-stall edge without exc_req: id_pc <= pc_f, id_valid <= 1, id_adel <= !im_valid sampled as registered with the address (im_valid captured at the same edge as pc_f).
REQ-022 DELAY_SLOT=0: the edge that applies a redirect SHALL write id_valid <= 0; DELAY_SLOT=1: id_valid <= 1.
REQ-023 exc_req edge SHALL write id_valid <= 0, id_adel <= 0, hold_valid <= 0 regardless of stall.
REQ-024 Skid hold: on a stall edge with hold_valid=0, hold_instr <= im_result and hold_valid <= 1; on any non-stall edge hold_valid <= 0.
REQ-025 id_instr = hold_valid ? hold_instr : im_result; id_instr SHALL read 0 when id_adel=1.
REQ-026 While stall=1 id_valid, id_pc, id_instr, id_adel SHALL remain stable for any stall length.
REQ-027 Misaligned or out-of-range targets SHALL still be loaded into pc_f; the error is reported only via id_adel, sequential fetch continues from pc_f+4.

Reset
REQ-028 reset_n=0 SHALL immediately force pc_f=RESET_PC, id_valid=0, id_pc=0, id_adel=0, hold_valid=0, pend_valid=0, im_enable=0.
REQ-029 Reset asserted mid-stall or with a pending redirect SHALL discard all pending state.
REQ-030 First edge after reset_n rises: id_pc=RESET_PC, id_valid=1, pc_f=RESET_PC+4.

Verification
REQ-031 Release reset, no stall, 4 edges -> id_pc 0x3000,0x3004,0x3008,0x300C with matching memory words, id_valid=1.
REQ-032 Stall 3 cycles while id_pc=0x3008 -> id_pc/id_instr frozen at 0x3008 word for all 3 cycles; next edge id_pc=0x300C.
REQ-033 redirect_valid with redirect_pc=0x3100 at id_pc=0x3004, DELAY_SLOT=1 -> next id_pc=0x3008 valid, then 0x3100; DELAY_SLOT=0 -> 0x3008 with id_valid=0, then 0x3100.
REQ-034 redirect 0x3200 during stall, stall held 2 more cycles -> pc_f unchanged until stall drops, then 0x3200 fetched.
REQ-035 exc_req while stall=1 -> id_valid=0 next cycle, pc_f=0x4180, following edge id_pc=0x4180.
REQ-036 redirect_pc=0x3002 -> id_adel=1, id_instr=0, next id_pc=0x3006 with id_adel=1; reset_n pulsed mid-sequence -> all outputs at reset values immediately.
